// File: rtl/line_printer.sv
// Buffered line printer: accepts bytes over the TR/RDY strobe handshake, queues them
// in a small FIFO and prints one every PRINT_CYCLES+1 cycles, tracking column and line.
module line_printer #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned PRINT_CYCLES = 13,
  parameter int unsigned LINE_WIDTH   = 80
) (
  input  logic                     CLK,
  input  logic                     RSTn,
  input  logic                     TR,
  input  logic [7:0]               PD,
  output logic                     RDY,
  output logic [7:0]               data,
  output logic                     data_valid,
  output logic                     line_done,
  output logic [7:0]               col,
  output logic [15:0]              line_count,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LVL_W = AW + 1;
  localparam int unsigned CNT_W = (PRINT_CYCLES > 1) ? $clog2(PRINT_CYCLES) : 1;

  typedef enum logic {IN_ACCEPT, IN_WAIT_LOW} in_state_e;
  typedef enum logic {ENG_IDLE, ENG_PRINT}    eng_state_e;

  in_state_e        in_q, in_d;
  eng_state_e       eng_q, eng_d;
  logic [7:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       byte_q, byte_d;
  logic [7:0]       data_q, data_d;
  logic [7:0]       col_q, col_d;
  logic [15:0]      line_count_q, line_count_d;
  logic             rdy_q, rdy_d;
  logic             dv_q, dv_d;
  logic             ld_q, ld_d;
  logic             busy_q, busy_d;
  logic             push_c, pop_c, full_c;

  assign full_c = (level_q == LVL_W'(DEPTH));

  // State and output registers
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      in_q         <= IN_ACCEPT;
      eng_q        <= ENG_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      cnt_q        <= '0;
      byte_q       <= '0;
      data_q       <= '0;
      col_q        <= '0;
      line_count_q <= '0;
      rdy_q        <= 1'b1;
      dv_q         <= 1'b0;
      ld_q         <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      in_q         <= in_d;
      eng_q        <= eng_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      cnt_q        <= cnt_d;
      byte_q       <= byte_d;
      data_q       <= data_d;
      col_q        <= col_d;
      line_count_q <= line_count_d;
      rdy_q        <= rdy_d;
      dv_q         <= dv_d;
      ld_q         <= ld_d;
      busy_q       <= busy_d;
    end
  end

  // FIFO storage; stale entries are harmless because the pointers are reset
  always_ff @(posedge CLK) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= PD;
    end
  end

  // Input handshake, print engine, FIFO bookkeeping and position tracking
  always_comb begin
    in_d         = in_q;
    eng_d        = eng_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    cnt_d        = cnt_q;
    byte_d       = byte_q;
    data_d       = data_q;
    col_d        = col_q;
    line_count_d = line_count_q;
    dv_d         = 1'b0;
    ld_d         = 1'b0;
    push_c       = 1'b0;
    pop_c        = 1'b0;

    unique case (in_q)
      IN_ACCEPT: begin
        if (TR && !full_c) begin
          push_c = 1'b1;
          in_d   = IN_WAIT_LOW;
        end
      end
      IN_WAIT_LOW: begin
        if (!TR) begin
          in_d = IN_ACCEPT;
        end
      end
    endcase

    unique case (eng_q)
      ENG_IDLE: begin
        if (level_q != '0) begin
          pop_c  = 1'b1;
          byte_d = mem_q[rd_ptr_q];
          cnt_d  = CNT_W'(PRINT_CYCLES - 1);
          eng_d  = ENG_PRINT;
        end
      end
      ENG_PRINT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          data_d = byte_q;
          dv_d   = 1'b1;
          eng_d  = ENG_IDLE;
          // LF ends the line, CR only returns the carriage, others advance/wrap
          if (byte_q == 8'h0A) begin
            ld_d         = 1'b1;
            col_d        = '0;
            line_count_d = line_count_q + 16'd1;
          end else if (byte_q == 8'h0D) begin
            col_d = '0;
          end else if (({1'b0, col_q} + 9'd1) == 9'(LINE_WIDTH)) begin
            ld_d         = 1'b1;
            col_d        = '0;
            line_count_d = line_count_q + 16'd1;
          end else begin
            col_d = col_q + 8'd1;
          end
        end
      end
    endcase

    if (push_c) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    unique case ({push_c, pop_c})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // Registered status reflects the state being entered at this edge
    rdy_d  = (in_d == IN_ACCEPT) && (level_d != LVL_W'(DEPTH));
    busy_d = (level_d != '0) || (eng_d == ENG_PRINT);
  end

  assign RDY        = rdy_q;
  assign data       = data_q;
  assign data_valid = dv_q;
  assign line_done  = ld_q;
  assign col        = col_q;
  assign line_count = line_count_q;
  assign busy       = busy_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_line_printer.sv
// Scoreboard bench for line_printer: a driver issues strobes and predicts each printed
// byte (value, timing, position); a monitor checks every cycle against that prediction.
module tb_line_printer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PC    = 13;
  localparam int unsigned LW    = 4;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        TR;
  logic [7:0]  PD;
  logic        RDY;
  logic [7:0]  data;
  logic        data_valid;
  logic        line_done;
  logic [7:0]  col;
  logic [15:0] line_count;
  logic        busy;
  logic [2:0]  fifo_level;

  line_printer #(.DEPTH(DEPTH), .PRINT_CYCLES(PC), .LINE_WIDTH(LW)) dut (
    .CLK(CLK), .RSTn(RSTn), .TR(TR), .PD(PD), .RDY(RDY), .data(data),
    .data_valid(data_valid), .line_done(line_done), .col(col),
    .line_count(line_count), .busy(busy), .fifo_level(fifo_level)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          t;
    logic [7:0]  b;
    logic        ld;
    logic [7:0]  col;
    logic [15:0] lc;
  } exp_t;

  exp_t        sb[$];
  int          cap_q[$];
  int          pop_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          lvl = 0;
  bit          wait_low = 0;
  bit          eng_busy = 0;
  bit          saw_full = 0;
  int          last_print = -1;
  int          mcol = 0;
  logic [15:0] mlc = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model of one accepted byte: when it prints and where it lands on the page
  task automatic model_capture(input logic [7:0] b, input int e);
    exp_t x;
    int   pop_t;
    pop_t      = ((e > last_print) ? e : last_print) + 1;
    last_print = pop_t + PC;
    cap_q.push_back(e);
    pop_q.push_back(pop_t);
    x.t  = last_print;
    x.b  = b;
    x.ld = 1'b0;
    if (b == 8'h0A) begin
      x.ld = 1'b1; mcol = 0; mlc = mlc + 16'd1;
    end else if (b == 8'h0D) begin
      mcol = 0;
    end else if (mcol + 1 == LW) begin
      x.ld = 1'b1; mcol = 0; mlc = mlc + 16'd1;
    end else begin
      mcol = mcol + 1;
    end
    x.col = 8'(mcol);
    x.lc  = mlc;
    sb.push_back(x);
  endtask

  // POC-style strobe: wait for RDY, raise TR for 'hold' cycles, then drop it
  task automatic send(input logic [7:0] b, input int hold);
    int w = 0;
    while (RDY !== 1'b1) begin
      @(negedge CLK);
      w++;
      if (w > 400) begin
        chk("rdy_wait_timeout", 32'(RDY), 32'd1);
        return;
      end
    end
    TR = 1'b1;
    PD = b;
    model_capture(b, cyc + 1);
    @(negedge CLK);
    chk("rdy_low_after_capture", 32'(RDY), 32'd0);
    repeat (hold - 1) @(negedge CLK);
    TR = 1'b0;
    PD = 8'($urandom);
  endtask

  task automatic wait_idle();
    int w = 0;
    while (sb.size() != 0 && w < 3000) begin
      @(negedge CLK);
      w++;
    end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge CLK);
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    TR   = 1'b0;
    sb.delete(); cap_q.delete(); pop_q.delete();
    lvl = 0; wait_low = 0; eng_busy = 0; last_print = -1; mcol = 0; mlc = '0;
    #1;
    chk("rst_rdy", 32'(RDY), 32'd1);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_dv", 32'(data_valid), 32'd0);
    chk("rst_ld", 32'(line_done), 32'd0);
    chk("rst_col", 32'(col), 32'd0);
    chk("rst_lc", 32'(line_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    repeat (3) @(negedge CLK);
    RSTn = 1'b1;
  endtask

  // Monitor: advance the expected occupancy/handshake state per edge and compare
  initial begin : monitor
    bit capd;
    forever begin
      @(posedge CLK);
      cyc++;
      #1;
      if (RSTn) begin
        capd = 0;
        while (cap_q.size() != 0 && cap_q[0] == cyc) begin
          void'(cap_q.pop_front()); lvl++; wait_low = 1; capd = 1;
        end
        if (!capd && !TR) wait_low = 0;
        while (pop_q.size() != 0 && pop_q[0] == cyc) begin
          void'(pop_q.pop_front()); lvl--; eng_busy = 1;
        end
        if (sb.size() != 0 && sb[0].t == cyc) begin
          exp_t x;
          x = sb.pop_front();
          eng_busy = 0;
          chk("print_dv", 32'(data_valid), 32'd1);
          chk("print_data", 32'(data), 32'(x.b));
          chk("print_ld", 32'(line_done), 32'(x.ld));
          chk("print_col", 32'(col), 32'(x.col));
          chk("print_lc", 32'(line_count), 32'(x.lc));
        end else begin
          chk("idle_dv", 32'(data_valid), 32'd0);
          chk("idle_ld", 32'(line_done), 32'd0);
        end
        chk("level", 32'(fifo_level), 32'(lvl));
        chk("rdy", 32'(RDY), 32'((!wait_low) && (lvl < DEPTH)));
        chk("busy", 32'(busy), 32'((lvl != 0) || eng_busy));
        if (fifo_level == 3'(DEPTH)) saw_full = 1;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] lt [8];
    lt = '{8'h0D, 8'h41, 8'h42, 8'h43, 8'h44, 8'h58, 8'h0A, 8'h59};
    RSTn = 1'b0; TR = 1'b0; PD = '0;
    @(negedge CLK);
    do_reset();

    // single byte with a two-cycle strobe
    send(8'h41, 2);
    wait_idle();
    chk("col_after_A", 32'(col), 32'd1);
    chk("busy_after_A", 32'(busy), 32'd0);

    // TR held for 20 cycles captures once
    send(8'h55, 20);
    wait_idle();

    // line handling with LINE_WIDTH=4
    foreach (lt[i]) send(lt[i], 1);
    send(8'h5A, 1);
    send(8'h0D, 1);
    wait_idle();
    chk("col_after_cr", 32'(col), 32'd0);
    chk("lc_after_lines", 32'(line_count), 32'd2);

    // burst that fills the FIFO
    saw_full = 0;
    for (int i = 0; i < 6; i++) send(8'(8'h30 + i), 1);
    wait_idle();
    chk("burst_saw_full", 32'(saw_full), 32'd1);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 7);
      if (r == 0) b = 8'h0A;
      else if (r == 1) b = 8'h0D;
      else b = 8'($urandom_range(32, 126));
      send(b, $urandom_range(1, 3));
      repeat ($urandom_range(0, 30)) @(negedge CLK);
    end
    wait_idle();

    // reset while printing with two bytes queued
    send(8'h61, 1); send(8'h62, 1); send(8'h63, 1);
    repeat (2) @(negedge CLK);
    chk("pre_reset_level", 32'(fifo_level), 32'd2);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    do_reset();
    repeat (40) @(negedge CLK);

    // line_count wrap from 0xFFFF
    force dut.line_count_q = 16'hFFFF;
    repeat (2) @(negedge CLK);
    release dut.line_count_q;
    mlc = 16'hFFFF;
    send(8'h0A, 1);
    wait_idle();
    chk("lc_wrap", 32'(line_count), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
